// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR engine: default tap count,
// default symmetric coefficient table, controller state encoding and the
// accumulator width helper. Pure package, no ports.
package fir_pkg;

  localparam int FIR_NTAPS_DEFAULT = 19;
  localparam int FIR_SAMPLE_W      = 16;
  localparam int FIR_COEF_W        = 16;
  localparam int FIR_PROD_W        = FIR_SAMPLE_W + FIR_COEF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Guard bits cover NTAPS full-scale products, so the sum can never wrap.
  function automatic int fir_acc_width(input int ntaps);
    return FIR_PROD_W + $clog2(ntaps);
  endfunction

  // Symmetric 19-tap low-pass table; taps beyond the table read as zero.
  function automatic logic [FIR_COEF_W-1:0] fir_default_coef(input int idx);
    logic [FIR_COEF_W-1:0] c;
    case (idx)
      0, 18:   c = 16'd26;
      1, 17:   c = 16'd270;
      2, 16:   c = 16'd963;
      3, 15:   c = 16'd2424;
      4, 14:   c = 16'd4869;
      5, 13:   c = 16'd8259;
      6, 12:   c = 16'd12194;
      7, 11:   c = 16'd15948;
      8, 10:   c = 16'd18666;
      9:       c = 16'd19660;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered unsigned multiply-accumulate: acc <= clr ? 0 : en ? acc + coef*sample : acc.
// Latency: one cycle from operands to updated acc. No backpressure.
// Ports: clk, rst (sync, active-high), clr, en, coef[15:0], sample[15:0], acc[ACC_W-1:0].
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int ACC_W = 37
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [FIR_COEF_W-1:0] coef,
  input  logic [FIR_SAMPLE_W-1:0] sample,
  output logic [ACC_W-1:0]      acc
);

  logic [FIR_PROD_W-1:0] prod;
  logic [ACC_W-1:0]      acc_d;
  logic [ACC_W-1:0]      acc_q;

  always_comb begin
    prod  = FIR_PROD_W'(coef) * FIR_PROD_W'(sample);
    acc_d = acc_q;
    // Clear wins over enable so a new sample always starts from zero.
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-FIR_PROD_W){1'b0}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: accepts one sample per handshake into a circular delay
//   line, then walks one shared MAC through all NTAPS taps and emits sat16(acc >> OUT_SHIFT).
// Latency: handshake in cycle t -> y_valid pulse in cycle t+NTAPS+1; next accept at t+NTAPS+2.
// Backpressure: x_ready only in IDLE; no output backpressure (sink must take y_valid).
// Ports: Clk, Rst (sync, active-high), X_input/x_valid/x_ready (sample in),
//   Y_output/y_valid (result, held between pulses), busy (MAC or OUT).
// Option FIR_COEF_LOAD_EN: adds coef_we/coef_addr/coef_data for a writable
//   coefficient bank (IDLE-only writes, out-of-range addresses dropped).
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS     = FIR_NTAPS_DEFAULT,
  parameter int OUT_SHIFT = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [FIR_SAMPLE_W-1:0] X_input,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic [15:0]             Y_output,
  output logic                    y_valid,
  output logic                    busy
`ifdef FIR_COEF_LOAD_EN
  ,
  input  logic                    coef_we,
  input  logic [4:0]              coef_addr,
  input  logic [FIR_COEF_W-1:0]   coef_data
`endif
);

  localparam int ACC_W = fir_acc_width(NTAPS);
  localparam int IDX_W = $clog2(NTAPS);
  // NTAPS reduced to IDX_W bits; modular add/sub in IDX_W bits stays exact
  // because every true result lies in 0..NTAPS-1.
  localparam logic [IDX_W-1:0] NT_IDX   = IDX_W'(NTAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

  fir_state_e state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [15:0]      y_hold_q, y_hold_d;
  logic [FIR_SAMPLE_W-1:0] ring_q [NTAPS];
  logic [FIR_SAMPLE_W-1:0] ring_d [NTAPS];

  logic                    accept;
  logic                    mac_clr;
  logic                    mac_en;
  logic [IDX_W-1:0]        rd_idx;
  logic [FIR_COEF_W-1:0]   coef_rd;
  logic [ACC_W-1:0]        mac_acc;
  logic [ACC_W-1:0]        acc_shr;
  logic [15:0]             sat_val;

`ifdef FIR_COEF_LOAD_EN
  logic [FIR_COEF_W-1:0] coef_q [NTAPS];
  logic [FIR_COEF_W-1:0] coef_d [NTAPS];
  logic                  coef_wr_ok;

  always_comb begin
    coef_d     = coef_q;
    coef_wr_ok = coef_we && (state_q == ST_IDLE) && (int'(coef_addr) < NTAPS);
    // A write on the handshake cycle lands before the first MAC cycle reads it.
    if (coef_wr_ok) begin
      coef_d[coef_addr] = coef_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= fir_default_coef(i);
      end
    end else begin
      coef_q <= coef_d;
    end
  end

  assign coef_rd = coef_q[k_q];
`else
  assign coef_rd = fir_default_coef(int'(k_q));
`endif

  // Newest sample sits at base; tap k reads (base - k) mod NTAPS.
  assign rd_idx = (base_q >= k_q) ? (base_q - k_q) : (base_q + NT_IDX - k_q);

  fir_mac_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .coef   (coef_rd),
    .sample (ring_q[rd_idx]),
    .acc    (mac_acc)
  );

  // Anything left above bit 15 after the shift saturates to full scale.
  assign acc_shr = mac_acc >> OUT_SHIFT;
  assign sat_val = (|acc_shr[ACC_W-1:16]) ? 16'hFFFF : acc_shr[15:0];

  assign accept = (state_q == ST_IDLE) && x_valid && !Rst;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    base_d   = base_q;
    k_d      = k_q;
    y_hold_d = y_hold_q;
    ring_d   = ring_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    x_ready  = 1'b0;
    y_valid  = 1'b0;
    busy     = 1'b0;
    Y_output = y_hold_q;

    case (state_q)
      ST_IDLE: begin
        x_ready = 1'b1;
        if (accept) begin
          ring_d[wr_ptr_q] = X_input;
          base_d           = wr_ptr_q;
          wr_ptr_d         = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
          k_d              = '0;
          mac_clr          = 1'b1;
          state_d          = ST_MAC;
        end
      end
      ST_MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (k_q == LAST_IDX) begin
          state_d = ST_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_OUT: begin
        // Drive the fresh result in the pulse cycle, then hold it.
        busy     = 1'b1;
        y_valid  = 1'b1;
        Y_output = sat_val;
        y_hold_d = sat_val;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs read as idle/reset values for the whole reset cycle.
    if (Rst) begin
      x_ready  = 1'b0;
      y_valid  = 1'b0;
      busy     = 1'b0;
      Y_output = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      k_q      <= '0;
      y_hold_q <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      k_q      <= k_d;
      y_hold_q <= y_hold_d;
      ring_q   <= ring_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: a 16-bit-shift instance and an
// unshifted instance share stimulus; expected outputs are hand-computed.
module tb_fir_mac_sequencer;

  localparam int NT  = 19;
  localparam int LAT = NT + 1;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] X_input;
  logic        x_valid;
  logic        x_ready, y_valid, busy;
  logic [15:0] Y_output;
  logic        x_ready_s0, y_valid_s0, busy_s0;
  logic [15:0] Y_output_s0;
`ifdef FIR_COEF_LOAD_EN
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  fir_mac_sequencer #(.NTAPS(NT), .OUT_SHIFT(16)) dut (
    .Clk(Clk), .Rst(Rst), .X_input(X_input), .x_valid(x_valid), .x_ready(x_ready),
    .Y_output(Y_output), .y_valid(y_valid), .busy(busy)
`ifdef FIR_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
`endif
  );

  fir_mac_sequencer #(.NTAPS(NT), .OUT_SHIFT(0)) dut_s0 (
    .Clk(Clk), .Rst(Rst), .X_input(X_input), .x_valid(x_valid), .x_ready(x_ready_s0),
    .Y_output(Y_output_s0), .y_valid(y_valid_s0), .busy(busy_s0)
`ifdef FIR_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
`endif
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp_s0;
    logic [15:0] exp_s16;
    bit          chk16;
  } vec_t;

  vec_t vecs[$];

  int coef_tab [NT] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
                        18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};
  // (1000 * prefix_sum(coef)) >> 16 as the delay line fills with 1000s.
  int k1000 [NT] = '{0, 4, 19, 56, 130, 256, 442, 685, 970, 1270,
                     1555, 1798, 1984, 2110, 2185, 2222, 2236, 2241, 2241};
  // 65535s displacing 1000s; -1 rows are not hand-computed. Row 8 sits just
  // below saturation, row 9 is the first saturated result.
  int ksat [NT] = '{2267, 2532, 3481, -1, -1, -1, -1, -1, 64888, 65535,
                    65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] x, input int e0, input int e16);
    vec_t v;
    v.x       = x;
    v.exp_s0  = e0[15:0];
    v.exp_s16 = (e16 < 0) ? 16'd0 : e16[15:0];
    v.chk16   = (e16 >= 0);
    vecs.push_back(v);
  endtask

  // Called right after the handshake edge (+#1); watches one full result window.
  task automatic collect(output logic [15:0] y0, output logic [15:0] y16,
                         output logic [15:0] h0, output logic [15:0] h16,
                         output int p0, output int p16, output int lat);
    y0 = '0; y16 = '0; p0 = 0; p16 = 0; lat = -1;
    for (int c = 1; c <= NT + 4; c++) begin
      @(negedge Clk);
      if (y_valid) begin
        p16++;
        y16 = Y_output;
        if (lat < 0) lat = c;
      end
      if (y_valid_s0) begin
        p0++;
        y0 = Y_output_s0;
      end
    end
    h0  = Y_output_s0;
    h16 = Y_output;
  endtask

  task automatic run_sample(input logic [15:0] x,
                            output logic [15:0] y0, output logic [15:0] y16,
                            output logic [15:0] h0, output logic [15:0] h16,
                            output int p0, output int p16, output int lat);
    int w;
    w = 0;
    @(negedge Clk);
    while (!x_ready && w < 50) begin
      @(negedge Clk);
      w++;
    end
    X_input = x;
    x_valid = 1'b1;
    @(posedge Clk);
    #1 x_valid = 1'b0;
    collect(y0, y16, h0, h16, p0, p16, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] y0, y16, h0, h16;
    int p0, p16, lat;
    int acc_cnt, last, bad_gap, viol, ypulse;

    Rst = 1'b1; X_input = '0; x_valid = 1'b0;
`ifdef FIR_COEF_LOAD_EN
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
`endif

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_x_ready", 32'(x_ready), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y_output", 32'(Y_output), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    check("idle_x_ready", 32'(x_ready), 32'd1);

    // Impulse, constant 1000, constant 65535
    for (int n = 0; n < NT; n++) add_vec((n == 0) ? 16'd1 : 16'd0, coef_tab[n], 0);
    for (int n = 0; n < NT; n++) add_vec(16'd1000, (n == 0) ? 26000 : 65535, k1000[n]);
    for (int n = 0; n < NT; n++) add_vec(16'd65535, 65535, ksat[n]);

    foreach (vecs[i]) begin
      run_sample(vecs[i].x, y0, y16, h0, h16, p0, p16, lat);
      check($sformatf("v%0d_y_s0", i), 32'(y0), 32'(vecs[i].exp_s0));
      check($sformatf("v%0d_hold_s0", i), 32'(h0), 32'(vecs[i].exp_s0));
      check($sformatf("v%0d_pulses", i), 32'(p16), 32'd1);
      check($sformatf("v%0d_pulses_s0", i), 32'(p0), 32'd1);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
      if (vecs[i].chk16) begin
        check($sformatf("v%0d_y_s16", i), 32'(y16), 32'(vecs[i].exp_s16));
        check($sformatf("v%0d_hold_s16", i), 32'(h16), 32'(vecs[i].exp_s16));
      end
    end

    // x_valid held high: one accept every NT+2 cycles, never ready while busy
    acc_cnt = 0; last = -1; bad_gap = 0; viol = 0; ypulse = 0;
    @(negedge Clk);
    X_input = 16'd5000;
    x_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (x_ready) begin
        if (last >= 0 && (c - last) != NT + 2) bad_gap++;
        last = c;
        acc_cnt++;
      end
      if (x_ready && busy) viol++;
      if (y_valid) ypulse++;
      @(negedge Clk);
    end
    x_valid = 1'b0;
    repeat (25) @(negedge Clk);
    check("stream_accepts", 32'(acc_cnt), 32'd4);
    check("stream_gap_errors", 32'(bad_gap), 32'd0);
    check("stream_ready_while_busy", 32'(viol), 32'd0);
    check("stream_y_pulses", 32'(ypulse), 32'd3);

    // Reset at tap k=7: result aborted, state as from reset
    @(negedge Clk);
    X_input = 16'd1;
    x_valid = 1'b1;
    @(posedge Clk);
    #1 x_valid = 1'b0;
    repeat (8) @(negedge Clk);
    check("mid_mac_busy", 32'(busy), 32'd1);
    check("mid_mac_x_ready", 32'(x_ready), 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    ypulse = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (y_valid || y_valid_s0) ypulse++;
    end
    check("abort_y_pulses", 32'(ypulse), 32'd0);
    check("abort_y_output", 32'(Y_output), 32'd0);
    check("abort_y_output_s0", 32'(Y_output_s0), 32'd0);
    check("abort_x_ready", 32'(x_ready), 32'd1);
    run_sample(16'd1, y0, y16, h0, h16, p0, p16, lat);
    check("post_abort_y0", 32'(y0), 32'd26);
    check("post_abort_latency", 32'(lat), 32'(LAT));
    run_sample(16'd0, y0, y16, h0, h16, p0, p16, lat);
    check("post_abort_y1", 32'(y0), 32'd270);

`ifdef FIR_COEF_LOAD_EN
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    // coefficient write on the same cycle as the impulse handshake
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'd100;
    X_input = 16'd1; x_valid = 1'b1;
    @(posedge Clk);
    #1 coef_we = 1'b0; x_valid = 1'b0;
    collect(y0, y16, h0, h16, p0, p16, lat);
    check("cload_coef0", 32'(y0), 32'd100);
    // write during MAC must be dropped
    @(negedge Clk);
    X_input = 16'd0; x_valid = 1'b1;
    @(posedge Clk);
    #1 x_valid = 1'b0;
    fork
      collect(y0, y16, h0, h16, p0, p16, lat);
      begin
        repeat (2) @(negedge Clk);
        coef_we = 1'b1; coef_addr = 5'd1; coef_data = 16'd7;
        repeat (5) @(negedge Clk);
        coef_we = 1'b0;
      end
    join
    check("cload_busy_write_ignored", 32'(y0), 32'd270);
    // out-of-range address must be dropped
    @(negedge Clk);
    coef_we = 1'b1; coef_addr = 5'd25; coef_data = 16'd1;
    X_input = 16'd0; x_valid = 1'b1;
    @(posedge Clk);
    #1 coef_we = 1'b0; x_valid = 1'b0;
    collect(y0, y16, h0, h16, p0, p16, lat);
    check("cload_addr25_ignored", 32'(y0), 32'd963);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
